// File: rtl/gene_pkg.sv
`default_nettype none
// ============================================================================
// gene_pkg : nucleotide ASCII/code constants, controller state type and the
//            character normalisation helper.              Revision: 1.0
// ============================================================================
package gene_pkg;

  localparam logic [7:0] ASCII_UA = 8'h41;
  localparam logic [7:0] ASCII_UC = 8'h43;
  localparam logic [7:0] ASCII_UG = 8'h47;
  localparam logic [7:0] ASCII_UT = 8'h54;
  localparam logic [7:0] ASCII_LA = 8'h61;
  localparam logic [7:0] ASCII_LC = 8'h63;
  localparam logic [7:0] ASCII_LG = 8'h67;
  localparam logic [7:0] ASCII_LT = 8'h74;

  localparam logic [1:0] CODE_A = 2'b00;
  localparam logic [1:0] CODE_C = 2'b01;
  localparam logic [1:0] CODE_G = 2'b10;
  localparam logic [1:0] CODE_T = 2'b11;

  localparam logic [7:0] PAD_CHAR_DEF = ASCII_UA;

  typedef enum logic [0:0] {COLLECT = 1'b0, HOLD = 1'b1} state_e;

  typedef struct packed {
    logic [7:0] ch;
    logic       invalid;
  } norm_t;

  // Uppercase ACGT pass through, lowercase is folded, anything else becomes pad.
  function automatic norm_t normalize(input logic [7:0] c, input logic [7:0] pad);
    norm_t r;
    r.ch      = pad;
    r.invalid = 1'b0;
    case (c)
      ASCII_UA, ASCII_UC, ASCII_UG, ASCII_UT: r.ch = c;
      ASCII_LA, ASCII_LC, ASCII_LG, ASCII_LT: r.ch = c - 8'h20;
      default:                                r.invalid = 1'b1;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gene_pack_ctrl_if.sv
`default_nettype none
// ============================================================================
// gene_pack_ctrl_if : input/output handshakes plus status of the controller.
//                                                         Revision: 1.0
// ============================================================================
interface gene_pack_ctrl_if #(
  parameter int COUNT_W = 32
);
  logic [7:0]         InData;
  logic               InValid;
  logic               InLast;
  logic               InReady;
  logic [7:0]         OutData;
  logic               OutValid;
  logic               OutReady;
  logic               OutLast;
  logic [1:0]         OutPad;
  logic               ErrClear;
  logic               ErrInvalid;
  logic [COUNT_W-1:0] SymCount;

  modport master (
    output InData, InValid, InLast, OutReady, ErrClear,
    input  InReady, OutData, OutValid, OutLast, OutPad, ErrInvalid, SymCount
  );

  modport slave (
    input  InData, InValid, InLast, OutReady, ErrClear,
    output InReady, OutData, OutValid, OutLast, OutPad, ErrInvalid, SymCount
  );
endinterface
`default_nettype wire

// File: rtl/FourByte2One.sv
`default_nettype none
// ============================================================================
// FourByte2One : packs four uppercase nucleotide bytes into one byte,
//                In0 in Out[7:6] down to In3 in Out[1:0].   Revision: 1.0
// ============================================================================
module FourByte2One
  import gene_pkg::*;
(
  input  logic [7:0] In0,
  input  logic [7:0] In1,
  input  logic [7:0] In2,
  input  logic [7:0] In3,
  output logic [7:0] Out
);

  function automatic logic [1:0] enc(input logic [7:0] c);
    case (c)
      ASCII_UC: enc = CODE_C;
      ASCII_UG: enc = CODE_G;
      ASCII_UT: enc = CODE_T;
      default:  enc = CODE_A;
    endcase
  endfunction

  assign Out = {enc(In0), enc(In1), enc(In2), enc(In3)};

endmodule
`default_nettype wire

// File: rtl/gene_pack_ctrl.sv
`default_nettype none
// ============================================================================
// gene_pack_ctrl : collects nucleotide bytes into groups of four, packs them
//                  and presents the result over a valid/ready output. Rev 1.0
// ============================================================================
module gene_pack_ctrl
  import gene_pkg::*;
#(
  parameter int         COUNT_W  = 32,
  parameter logic [7:0] PAD_CHAR = PAD_CHAR_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  gene_pack_ctrl_if.slave  bus
);

  localparam logic [0:0] S_COLLECT = COLLECT;
  localparam logic [0:0] S_HOLD    = HOLD;

  logic [0:0]         state;
  logic [1:0]         slot;
  logic [7:0]         buf_q [3];
  logic [7:0]         held_data;
  logic               held_last;
  logic [1:0]         held_pad;
  logic [7:0]         out_data;
  logic               out_valid;
  logic               out_last;
  logic [1:0]         out_pad;
  logic               err;
  logic [COUNT_W-1:0] cnt;

  logic       in_ready;
  logic       accept;
  logic       close;
  logic       out_free;
  norm_t      norm;
  logic [7:0] grp [4];
  logic [7:0] packed_byte;
  logic [1:0] close_pad;

  assign in_ready  = !Reset && (state == S_COLLECT);
  assign accept    = bus.InValid && in_ready;
  assign norm      = normalize(bus.InData, PAD_CHAR);
  assign close     = accept && ((slot == 2'd3) || bus.InLast);
  assign out_free  = !out_valid || bus.OutReady;
  assign close_pad = 2'd3 - slot;

  // The closing byte fills its own slot; later slots are padding.
  always_comb begin
    grp[0] = (slot == 2'd0) ? norm.ch : buf_q[0];
    grp[1] = (slot == 2'd1) ? norm.ch : ((slot > 2'd1) ? buf_q[1] : PAD_CHAR);
    grp[2] = (slot == 2'd2) ? norm.ch : ((slot == 2'd3) ? buf_q[2] : PAD_CHAR);
    grp[3] = (slot == 2'd3) ? norm.ch : PAD_CHAR;
  end

  FourByte2One u_pack (
    .In0 (grp[0]),
    .In1 (grp[1]),
    .In2 (grp[2]),
    .In3 (grp[3]),
    .Out (packed_byte)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= S_COLLECT;
      slot      <= 2'd0;
      buf_q[0]  <= 8'h00;
      buf_q[1]  <= 8'h00;
      buf_q[2]  <= 8'h00;
      held_data <= 8'h00;
      held_last <= 1'b0;
      held_pad  <= 2'd0;
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_pad   <= 2'd0;
      err       <= 1'b0;
      cnt       <= '0;
    end else begin
      if (accept) begin
        if (close) begin
          slot <= 2'd0;
        end else begin
          case (slot)
            2'd0:    buf_q[0] <= norm.ch;
            2'd1:    buf_q[1] <= norm.ch;
            default: buf_q[2] <= norm.ch;
          endcase
          slot <= slot + 2'd1;
        end
        if (cnt != '1) cnt <= cnt + 1'b1;
      end

      // A new invalid character takes priority over a coincident clear.
      if (accept && norm.invalid) err <= 1'b1;
      else if (bus.ErrClear)      err <= 1'b0;

      if (state == S_HOLD) begin
        if (out_valid && bus.OutReady) begin
          out_data <= held_data;
          out_last <= held_last;
          out_pad  <= held_pad;
          state    <= S_COLLECT;
        end
      end else if (close && out_free) begin
        out_valid <= 1'b1;
        out_data  <= packed_byte;
        out_last  <= bus.InLast;
        out_pad   <= close_pad;
      end else begin
        if (close) begin
          held_data <= packed_byte;
          held_last <= bus.InLast;
          held_pad  <= close_pad;
          state     <= S_HOLD;
        end
        if (out_valid && bus.OutReady) out_valid <= 1'b0;
      end
    end
  end

  assign bus.InReady    = in_ready;
  assign bus.OutData    = out_data;
  assign bus.OutValid   = out_valid;
  assign bus.OutLast    = out_last;
  assign bus.OutPad     = out_pad;
  assign bus.ErrInvalid = err;
  assign bus.SymCount   = cnt;

endmodule
`default_nettype wire

// File: tb/tb_gene_pack_ctrl.sv
`default_nettype none
// ============================================================================
// tb_gene_pack_ctrl : directed stimulus against a queue-based reference model.
//                                                         Revision: 1.0
// ============================================================================
module tb_gene_pack_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gene_pack_ctrl_if #(.COUNT_W(32)) bus ();

  gene_pack_ctrl #(.COUNT_W(32), .PAD_CHAR(8'h41)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic [1:0] pad;
  } exp_t;

  exp_t        exp_q [$];
  int          grp [$];
  int unsigned m_cnt;
  bit          m_err;
  bit          m_acc;
  bit          m_bad;
  exp_t        m_e;
  int          vectors = 0;
  int          fails   = 0;

  function automatic bit is_nuc(input logic [7:0] c);
    return c inside {"A", "C", "G", "T", "a", "c", "g", "t"};
  endfunction

  function automatic int nuc_code(input logic [7:0] c);
    case (c)
      "C", "c": return 1;
      "G", "g": return 2;
      "T", "t": return 3;
      default:  return 0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference model: an output is pending while in exp_q; at most two can be
  // outstanding (output register plus one held group).
  always @(posedge clk) begin
    if (!rst) begin
      m_acc = bus.InValid && (exp_q.size() < 2);
      if (exp_q.size() > 0 && bus.OutReady) void'(exp_q.pop_front());
      m_bad = 1'b0;
      if (m_acc) begin
        m_bad = !is_nuc(bus.InData);
        grp.push_back(m_bad ? 0 : nuc_code(bus.InData));
        if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
        if (grp.size() == 4 || bus.InLast) begin
          m_e.data = 8'h00;
          for (int i = 0; i < grp.size(); i++) m_e.data |= 8'(grp[i] << (6 - 2 * i));
          m_e.pad  = 2'(4 - grp.size());
          m_e.last = bus.InLast;
          exp_q.push_back(m_e);
          grp.delete();
        end
      end
      if (m_bad)             m_err = 1'b1;
      else if (bus.ErrClear) m_err = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("in_ready",  bus.InReady,  32'(exp_q.size() < 2));
      check("out_valid", bus.OutValid, 32'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        check("out_data", bus.OutData, exp_q[0].data);
        check("out_last", bus.OutLast, exp_q[0].last);
        check("out_pad",  bus.OutPad,  exp_q[0].pad);
      end
      check("sym_count",   bus.SymCount,   m_cnt);
      check("err_invalid", bus.ErrInvalid, m_err);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    grp.delete();
    m_cnt = 0;
    m_err = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] ch, input bit last);
    bit ok;
    ok = 1'b0;
    bus.InData  = ch;
    bus.InLast  = last;
    bus.InValid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      if (bus.InReady) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      vectors++;
      fails++;
      $display("FAIL send_timeout: byte %h not accepted within 50 cycles", ch);
    end
    @(negedge clk);
    bus.InValid = 1'b0;
    bus.InLast  = 1'b0;
  endtask

  task automatic send_str(input string s, input bit last_on_end);
    for (int i = 0; i < s.len(); i++) send(s[i], last_on_end && (i == s.len() - 1));
  endtask

  initial begin
    rst          = 1'b1;
    bus.InData   = 8'h00;
    bus.InValid  = 1'b0;
    bus.InLast   = 1'b0;
    bus.OutReady = 1'b1;
    bus.ErrClear = 1'b0;
    m_cnt = 0;
    m_err = 1'b0;
    @(negedge clk);
    check("rst_in_ready",  bus.InReady,    0);
    check("rst_out_valid", bus.OutValid,   0);
    check("rst_out_data",  bus.OutData,    0);
    check("rst_sym_count", bus.SymCount,   0);
    check("rst_err",       bus.ErrInvalid, 0);
    @(negedge clk);
    rst = 1'b0;

    send_str("ACGT", 1'b0);
    check("acgt_valid", bus.OutValid, 1);
    check("acgt_data",  bus.OutData,  8'h1B);
    check("acgt_pad",   bus.OutPad,   0);
    check("acgt_last",  bus.OutLast,  0);

    send_str("GA", 1'b1);
    check("ga_data", bus.OutData, 8'h80);
    check("ga_pad",  bus.OutPad,  2);
    check("ga_last", bus.OutLast, 1);
    @(negedge clk);

    bus.OutReady = 1'b0;
    send_str("AAAACCCC", 1'b0);
    check("hold_in_ready", bus.InReady,  0);
    check("hold_data",     bus.OutData,  8'h00);
    check("hold_valid",    bus.OutValid, 1);
    bus.OutReady = 1'b1;
    @(negedge clk);
    check("release_data",  bus.OutData,  8'h55);
    check("release_ready", bus.InReady,  1);
    @(negedge clk);
    check("drained_valid", bus.OutValid, 0);

    do_reset();
    send_str("ANgt", 1'b0);
    check("angt_data",  bus.OutData,    8'h0B);
    check("angt_err",   bus.ErrInvalid, 1);
    check("angt_count", bus.SymCount,   4);
    bus.ErrClear = 1'b1;
    @(negedge clk);
    bus.ErrClear = 1'b0;
    check("err_cleared", bus.ErrInvalid, 0);
    bus.ErrClear = 1'b1;
    send("X", 1'b0);
    bus.ErrClear = 1'b0;
    check("err_set_wins", bus.ErrInvalid, 1);

    do_reset();
    send_str("AC", 1'b0);
    do_reset();
    send_str("GGGG", 1'b0);
    check("gggg_data",  bus.OutData,  8'hAA);
    check("gggg_count", bus.SymCount, 4);
    @(negedge clk);

    send_str("TTTT", 1'b0);
    check("tttt_data", bus.OutData, 8'hFF);
    check("tttt_pad",  bus.OutPad,  0);
    send("T", 1'b1);
    check("t_last_data", bus.OutData, 8'hC0);
    check("t_last_pad",  bus.OutPad,  3);
    check("t_last_last", bus.OutLast, 1);

    repeat (3) @(negedge clk);
    check("model_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/gene_pack_ctrl.md
Name: gene_pack_ctrl

Overview:
Stream controller that sequences the existing four-to-one nucleotide packer (FourByte2One). It accepts one ASCII nucleotide byte per cycle over a valid/ready handshake and collects groups of four. It drives the packer with each complete group and presents the packed byte downstream over a second valid/ready handshake. It also handles end-of-sequence padding, invalid characters, backpressure and a running symbol count.

Parameters:
COUNT_W, 32, width of the accepted-symbol counter
PAD_CHAR, 8'h41 ('A'), character substituted for padding and for invalid input

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high reset
InData  in  8  ASCII nucleotide byte
InValid  in  1  InData valid
InLast  in  1  qualifies the final byte of a sequence
InReady  out  1  controller can accept a byte this cycle
OutData  out  8  packed byte from FourByte2One
OutValid  out  1  OutData valid
OutReady  in  1  downstream accepts OutData
OutLast  out  1  packed byte contains the final symbol of the sequence
OutPad  out  2  number of padded slots in this byte (0-3)
ErrClear  in  1  clears ErrInvalid
ErrInvalid  out  1  sticky: an invalid character was seen
SymCount  out  COUNT_W  accepted input bytes, saturating

Behaviour:
- Reset (async) clears: InReady=0 during reset, then 1; OutValid=0; OutData=0; OutLast=0; OutPad=0; ErrInvalid=0; SymCount=0; slot counter=0; state=COLLECT.
- A partial group in progress at reset is discarded.
- Accept: a byte is accepted when InValid && InReady.
- Packing order: the 1st byte of a group drives In0 (Out[7:6]), the 2nd drives In1, the 3rd In2, the 4th In3 (Out[1:0]).
- Codes: A=00, C=01, G=10, T=11.
- Normalisation: lowercase a/c/g/t are converted to uppercase before buffering.
- Invalid bytes (anything else) are still accepted, replaced by PAD_CHAR, and set ErrInvalid.
- ErrInvalid clears only on ErrClear or Reset. If a set and ErrClear occur in the same cycle, set wins.
- SymCount increments on each accepted byte and saturates at all-ones.
- Slot counter 0..3 advances on each accept. A group closes when the 4th byte is accepted, or when a byte with InLast=1 is accepted.
- On close, unfilled slots are driven with PAD_CHAR. OutPad = 3 - slot index of the closing byte. OutLast = InLast of the closing byte. The slot counter returns to 0.
- States:
  - COLLECT: InReady=1. On close, if the output register is free (!OutValid || OutReady), OutData/OutLast/OutPad load at the next edge. Latency is 1 cycle from the closing accept to OutValid=1. If the output register is not free, the closing byte is stored and the state moves to HOLD.
  - HOLD: InReady=0. When OutValid && OutReady, the held group loads into the output register at that edge and the state returns to COLLECT.
- Output register: OutValid stays high and OutData/OutLast/OutPad are stable until OutReady. OutValid deasserts on consume unless a new group loads in the same edge.
- Throughput: sustained 1 input byte/cycle with OutReady=1. No bubbles between groups.
- InLast at slot 0: emits one byte with OutPad=3. InLast on the 4th byte: OutPad=0, OutLast=1.

Decomposition:
- Shared package gene_pkg holds:
  - ASCII constants for A/C/G/T and their lowercase forms.
  - The 2-bit code constants.
  - The PAD_CHAR default.
  - The state enum {COLLECT, HOLD}.
- One sub-module: the existing FourByte2One, instantiated unchanged as the packing datapath.
- Character normalisation/validation is a small combinational function in gene_pkg.

Test Plan:
- "ACGT", OutReady=1 -> OutData=0x1B one cycle after the 4th accept; OutPad=0, OutLast=0.
- "GA" with InLast on 'A' -> OutData=0x80, OutPad=2, OutLast=1.
- "AAAACCCC" with OutReady=0 -> 0x00 held; InReady drops after the 8th accept (HOLD). Raise OutReady -> 0x00 then 0x55 on consecutive cycles; InReady returns to 1.
- "ANgt" -> OutData=0x0B, ErrInvalid=1, SymCount=4. ErrClear pulse -> ErrInvalid=0. ErrClear coincident with invalid 'X' -> ErrInvalid stays 1.
- "AC", then Reset mid-group, then "GGGG" -> only OutData=0xAA emitted; SymCount=4.
- "TTTT" and "T" with InLast in back-to-back cycles -> 0xFF (OutPad=0) then 0xC0 (OutPad=3, OutLast=1); no InReady deassertion.
